cache_ctrl: RTL and testbench

- Per-cache sequencing FSM that sits between the CPU load/store port, the set-associative way/replacement block and the memory bus.
- Accepts one CPU access at a time and runs a lookup. On a hit it updates the replacement order. On a miss it writes back the dirty victim line if needed, refills the line word-by-word, then re-runs the lookup.
- Also keeps hit and miss counters for performance reporting.

---
 rtl/cache_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: per-cache sequencing FSM between the CPU port, the way block and the memory bus.
// One access at a time: lookup, then on a miss an optional dirty writeback, a word refill and a re-lookup.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cpu_*                CPU request (held until cpu_done), load data, done pulse, stall
//   set_*                way block: hit/dirty/victim inputs, update/store/writeback/fill strobes
//   mem_*                memory bus: burst request, beat address/data, per-beat ready
//   hit_cnt, miss_cnt    wrapping performance counters
module cache_ctrl #(
  parameter int TAG_WIDTH    = 22,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wen,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_done,
  output logic                    cpu_stall,
  input  logic                    set_hit,
  input  logic                    set_dirty,
  input  logic [TAG_WIDTH-1:0]    set_replace_tag,
  input  logic [31:0]             set_read_data,
  input  logic [31:0]             set_wb_data,
  output logic                    set_en,
  output logic                    set_wen,
  output logic [OFFSET_WIDTH-3:0] set_wb_word,
  output logic                    set_fill_wen,
  output logic [OFFSET_WIDTH-3:0] set_fill_word,
  output logic [31:0]             set_fill_data,
  output logic                    set_fill_done,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int WW = OFFSET_WIDTH - 2;
  localparam logic [WW-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          first_q, first_d;
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_WIDTH-1:0] tag;
  logic [SET_WIDTH-1:0] set_idx;

  assign tag     = addr_q[31 -: TAG_WIDTH];
  assign set_idx = addr_q[OFFSET_WIDTH +: SET_WIDTH];

  // Store data is consumed by the way block straight from the CPU port.
  logic unused;
  assign unused = ^{wdata_q, addr_q[1:0]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    first_d       = first_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cpu_rdata     = '0;
    cpu_done      = 1'b0;
    set_en        = 1'b0;
    set_wen       = 1'b0;
    set_wb_word   = '0;
    set_fill_wen  = 1'b0;
    set_fill_word = '0;
    set_fill_data = '0;
    set_fill_done = 1'b0;
    mem_req       = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wen_d   = cpu_wen;
          wdata_d = cpu_wdata;
          first_d = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (set_hit) begin
          cpu_done  = 1'b1;
          set_en    = 1'b1;
          set_wen   = wen_q;
          cpu_rdata = set_read_data;
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = IDLE;
        end else begin
          // Only the first lookup of an access counts as a miss.
          if (first_q) miss_cnt_d = miss_cnt_q + 32'd1;
          first_d = 1'b0;
          cnt_d   = '0;
          state_d = set_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req     = 1'b1;
        mem_wen     = 1'b1;
        mem_addr    = {set_replace_tag, set_idx, cnt_q, 2'b00};
        mem_wdata   = set_wb_data;
        set_wb_word = cnt_q;
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, set_idx, cnt_q, 2'b00};
        if (mem_ready) begin
          set_fill_wen  = 1'b1;
          set_fill_word = cnt_q;
          set_fill_data = mem_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            set_fill_done = 1'b1;
            state_d       = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset edge aborts the burst: never write or validate a partial line.
    if (reset) begin
      set_fill_wen  = 1'b0;
      set_fill_done = 1'b0;
      cpu_done      = 1'b0;
      set_en        = 1'b0;
      set_wen       = 1'b0;
    end
  end

  assign cpu_stall = (cpu_req | (state_q != IDLE)) & ~cpu_done;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and randomized accesses against an access-level reference model.
// The bench plays both the way block and the memory, and predicts every cycle of each access.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        set_hit, set_dirty;
  logic [21:0] set_replace_tag;
  logic [31:0] set_read_data, set_wb_data;
  logic        set_en, set_wen;
  logic [2:0]  set_wb_word, set_fill_word;
  logic        set_fill_wen, set_fill_done;
  logic [31:0] set_fill_data;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_stall(cpu_stall),
    .set_hit(set_hit), .set_dirty(set_dirty),
    .set_replace_tag(set_replace_tag),
    .set_read_data(set_read_data),
    .set_wb_data(set_wb_data),
    .set_en(set_en), .set_wen(set_wen),
    .set_wb_word(set_wb_word),
    .set_fill_wen(set_fill_wen),
    .set_fill_word(set_fill_word),
    .set_fill_data(set_fill_data),
    .set_fill_done(set_fill_done),
    .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Victim word pattern produced by the modelled way block.
  assign set_wb_data = 32'hB0B0_0000 | {29'b0, set_wb_word};

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hit = '0;
  logic [31:0] m_miss = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One access: hit or miss (dirty or clean), memory acking every per-th cycle.
  task automatic access(input logic [31:0] a, input logic w,
                        input logic hit, input logic dirty,
                        input logic [21:0] rt, input int per);
    int nwb, nb, done_c;
    logic [31:0] rd, fd, ea;
    logic [4:0] st;
    logic [21:0] tg;
    nwb = (!hit && dirty) ? 8 : 0;
    nb = hit ? 0 : nwb + 8;
    done_c = hit ? 1 : 2 + nb * per;
    st = a[9:5];
    tg = a[31:10];
    for (int c = 0; c <= done_c; c++) begin
      int k, b;
      logic burst, beat;
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1;
        cpu_addr = a;
        cpu_wen = w;
        cpu_wdata = $urandom;
      end
      burst = !hit && c >= 2 && c < done_c;
      k = c - 2;
      b = burst ? k / per : 0;
      beat = burst && (k % per == per - 1);
      mem_ready = burst ? beat : 1'($urandom);
      set_hit = (c == 1) ? hit : (c == done_c) ? 1'b1 : 1'($urandom);
      set_dirty = (c == 1) ? dirty : 1'($urandom);
      set_replace_tag = rt;
      rd = $urandom;
      set_read_data = rd;
      fd = $urandom;
      mem_rdata = fd;
      #1;
      chk1("cpu_done", cpu_done, c == done_c);
      chk1("cpu_stall", cpu_stall, c < done_c);
      chk1("mem_req", mem_req, burst);
      chk1("fill_wen", set_fill_wen, beat && b >= nwb);
      chk1("fill_done", set_fill_done, beat && b == nb - 1);
      if (burst) begin
        ea = (b < nwb) ? {rt, st, b[2:0], 2'b00}
                       : {tg, st, 3'(b - nwb), 2'b00};
        chk("mem_addr", mem_addr, ea);
        chk1("mem_wen", mem_wen, b < nwb);
        if (b < nwb) begin
          chk("mem_wdata", mem_wdata, 32'hB0B0_0000 | b);
          chk("wb_word", {29'b0, set_wb_word}, b);
        end
        if (beat && b >= nwb) begin
          chk("fill_word", {29'b0, set_fill_word}, b - nwb);
          chk("fill_data", set_fill_data, fd);
        end
      end
      if (c == done_c) begin
        chk("cpu_rdata", cpu_rdata, rd);
        chk1("set_en", set_en, 1'b1);
        chk1("set_wen", set_wen, w);
      end
    end
    if (!hit) m_miss++;
    m_hit++;
    @(posedge clk);
    #1;
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    set_hit = 0; set_dirty = 0; set_replace_tag = '0;
    set_read_data = '0; mem_rdata = '0; mem_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_done", cpu_done, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_stall", cpu_stall, 1'b0);
    chk1("rst_fill_wen", set_fill_wen, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    access(32'h0000_1040, 1'b0, 1'b1, 1'b0, 22'h0, 1);
    access(32'h0000_2004, 1'b0, 1'b0, 1'b0, 22'h0, 1);
    access(32'h0000_2468, 1'b1, 1'b0, 1'b1, 22'h3, 1);
    access(32'h0000_3010, 1'b0, 1'b0, 1'b0, 22'h0, 3);
    access(32'h0001_70A0, 1'b1, 1'b0, 1'b1, 22'h2A5, 3);
    access(32'h0000_1044, 1'b1, 1'b1, 1'b0, 22'h0, 1);
    access(32'h0000_1048, 1'b0, 1'b1, 1'b0, 22'h0, 1);

    for (int i = 0; i < 30; i++) begin
      access($urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom),
             1'($urandom), 22'($urandom), $urandom_range(1, 3));
    end

    // Reset during refill beat 4 of a clean miss.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_2004; cpu_wen = 1'b0;
    set_hit = 1'b0; set_dirty = 1'b0; mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("rst_mid_fill_done", set_fill_done, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_mid_mem_req", mem_req, 1'b0);
    chk1("rst_mid_fill_done2", set_fill_done, 1'b0);
    chk1("rst_mid_done", cpu_done, 1'b0);
    chk("rst_mid_hit_cnt", hit_cnt, 32'h0);
    chk("rst_mid_miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    m_hit = '0;
    m_miss = '0;
    #1;
    chk1("post_rst_mem_req", mem_req, 1'b0);
    access(32'h0000_2004, 1'b0, 1'b0, 1'b0, 22'h0, 1);

    // Hit counter wraps to zero.
    @(negedge clk);
    cpu_req = 1'b0;
    dut.hit_cnt_q = 32'hFFFF_FFFF;
    m_hit = 32'hFFFF_FFFF;
    access(32'h0000_1040, 1'b0, 1'b1, 1'b0, 22'h0, 1);
    chk("hit_wrap", hit_cnt, 32'h0);

    @(negedge clk);
    cpu_req = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
